// File: rtl/bus_load_decoder.sv
// Sink side of the shared CPU bus: decodes dest_sel and captures BusMuxOut into R0-R15/HI/LO/Y/PC/MAR/IR.
// Latency: single load visible 1 clk after the sampling edge; a LO/HI pair completes 2 clk after its sampling edge.
// Backpressure: none; IDLE accepts a request every cycle, load_req is ignored while the HI beat of a pair is pending.
// Option: define BUS_R0_ZERO_EN to hard-wire R0 to zero (writes to code 0 are discarded, still acknowledged).
module bus_load_decoder #(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_GPR  = 16,   // codes 0..NUM_GPR-1; must not exceed 16
    parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic [DATA_W-1:0]           BusMuxOut,
    input  logic                        load_req,
    input  logic [4:0]                  dest_sel,
    input  logic                        pair_mode,
    output logic                        load_ack,
    output logic                        load_busy,
    output logic                        load_err,
    output logic [21:0]                 load_en,
    output logic [NUM_GPR*DATA_W-1:0]   BusMuxInR_flat,
    output logic [DATA_W-1:0]           BusMuxInHI,
    output logic [DATA_W-1:0]           BusMuxInLO,
    output logic [DATA_W-1:0]           BusMuxInY,
    output logic [DATA_W-1:0]           BusMuxInPC,
    output logic [DATA_W-1:0]           MARout,
    output logic [DATA_W-1:0]           IRout
);

    localparam int CODE_HI  = 16;
    localparam int CODE_LO  = 17;
    localparam int CODE_Y   = 18;
    localparam int CODE_PC  = 19;
    localparam int CODE_MAR = 20;
    localparam int CODE_IR  = 21;

    typedef enum logic {
        IDLE    = 1'b0,
        PAIR_HI = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [21:0]         en_q, en_d;
    logic                wr_single;   // single-beat write to the register named by dest_sel
    logic                wr_lo;       // first beat of a pair
    logic                wr_hi;       // second beat of a pair
    logic                code_valid;

    logic [DATA_W-1:0]   gpr_q [NUM_GPR];
    logic [DATA_W-1:0]   hi_q, lo_q, y_q, pc_q, mar_q, ir_q;

    // Codes 0..NUM_GPR-1 select a GPR; 16..21 select the special registers.
    assign code_valid = (int'(dest_sel) < NUM_GPR) ||
                        ((int'(dest_sel) >= CODE_HI) && (int'(dest_sel) <= CODE_IR));

    // Next-state, write strobes and the registered status outputs for the following cycle.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        en_d      = '0;
        wr_single = 1'b0;
        wr_lo     = 1'b0;
        wr_hi     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    if (pair_mode) begin
                        wr_lo           = 1'b1;
                        en_d[CODE_LO]   = 1'b1;
                        state_d         = PAIR_HI;
                    end else if (code_valid) begin
                        wr_single = 1'b1;
                        ack_d     = 1'b1;
                        for (int i = 0; i < 22; i++) begin
                            en_d[i] = (int'(dest_sel) == i);
                        end
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            PAIR_HI: begin
                // HI beat is taken unconditionally; any load_req now is dropped.
                wr_hi         = 1'b1;
                en_d[CODE_HI] = 1'b1;
                ack_d         = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and status pulses; clear overrides everything, including a pending HI beat.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            en_q    <= en_d;
        end
    end

    // Register file capture: full-width copy of the bus into the selected register.
    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            pc_q  <= PC_RESET;
            mar_q <= '0;
            ir_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
`ifdef BUS_R0_ZERO_EN
                if (wr_single && (int'(dest_sel) == i) && (i != 0)) begin
                    gpr_q[i] <= BusMuxOut;
                end
`else
                if (wr_single && (int'(dest_sel) == i)) begin
                    gpr_q[i] <= BusMuxOut;
                end
`endif
            end
            if (wr_hi || (wr_single && int'(dest_sel) == CODE_HI)) hi_q  <= BusMuxOut;
            if (wr_lo || (wr_single && int'(dest_sel) == CODE_LO)) lo_q  <= BusMuxOut;
            if (wr_single && int'(dest_sel) == CODE_Y)             y_q   <= BusMuxOut;
            if (wr_single && int'(dest_sel) == CODE_PC)            pc_q  <= BusMuxOut;
            if (wr_single && int'(dest_sel) == CODE_MAR)           mar_q <= BusMuxOut;
            if (wr_single && int'(dest_sel) == CODE_IR)            ir_q  <= BusMuxOut;
        end
    end

    // GPR contents flattened for the bus mux, R0 in the lowest word.
    for (genvar g = 0; g < NUM_GPR; g++) begin : g_flat
`ifdef BUS_R0_ZERO_EN
        if (g == 0) begin : g_zero
            assign BusMuxInR_flat[g*DATA_W +: DATA_W] = '0;
        end else begin : g_reg
            assign BusMuxInR_flat[g*DATA_W +: DATA_W] = gpr_q[g];
        end
`else
        assign BusMuxInR_flat[g*DATA_W +: DATA_W] = gpr_q[g];
`endif
    end

    assign load_ack   = ack_q;
    assign load_err   = err_q;
    assign load_en    = en_q;
    assign load_busy  = (state_q == PAIR_HI);
    assign BusMuxInHI = hi_q;
    assign BusMuxInLO = lo_q;
    assign BusMuxInY  = y_q;
    assign BusMuxInPC = pc_q;
    assign MARout     = mar_q;
    assign IRout      = ir_q;

endmodule

// File: tb/tb_bus_load_decoder.sv
// Bench for bus_load_decoder: directed scenarios followed by random traffic.
// Expected values come from a register-array model updated once per clock edge.
// All outputs are compared 1 time unit after every rising edge.
module tb_bus_load_decoder;

    localparam int          DATA_W   = 32;
    localparam int          NUM_GPR  = 16;
    localparam logic [31:0] PC_RST   = 32'h0000_0100;

    logic                       clock;
    logic                       clear;
    logic [DATA_W-1:0]          BusMuxOut;
    logic                       load_req;
    logic [4:0]                 dest_sel;
    logic                       pair_mode;
    logic                       load_ack;
    logic                       load_busy;
    logic                       load_err;
    logic [21:0]                load_en;
    logic [NUM_GPR*DATA_W-1:0]  BusMuxInR_flat;
    logic [DATA_W-1:0]          BusMuxInHI, BusMuxInLO, BusMuxInY, BusMuxInPC, MARout, IRout;

    int checks = 0;
    int errors = 0;

    // Model state: register contents by dest code, plus expected status outputs.
    logic [31:0] m_reg [22];
    logic        m_pair;
    logic        m_ack, m_err;
    logic [21:0] m_en;

    bus_load_decoder #(.DATA_W(DATA_W), .NUM_GPR(NUM_GPR), .PC_RESET(PC_RST)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .load_req(load_req),
        .dest_sel(dest_sel), .pair_mode(pair_mode), .load_ack(load_ack),
        .load_busy(load_busy), .load_err(load_err), .load_en(load_en),
        .BusMuxInR_flat(BusMuxInR_flat), .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO),
        .BusMuxInY(BusMuxInY), .BusMuxInPC(BusMuxInPC), .MARout(MARout), .IRout(IRout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] dut_reg(int code);
        case (code)
            16:      return BusMuxInHI;
            17:      return BusMuxInLO;
            18:      return BusMuxInY;
            19:      return BusMuxInPC;
            20:      return MARout;
            21:      return IRout;
            default: return BusMuxInR_flat[code*32 +: 32];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string step_name);
        chk({step_name, " ack"},  {31'd0, load_ack},  {31'd0, m_ack});
        chk({step_name, " err"},  {31'd0, load_err},  {31'd0, m_err});
        chk({step_name, " busy"}, {31'd0, load_busy}, {31'd0, m_pair});
        chk({step_name, " en"},   {10'd0, load_en},   {10'd0, m_en});
        for (int c = 0; c < 22; c++) begin
            chk($sformatf("%s reg%0d", step_name, c), dut_reg(c), m_reg[c]);
        end
    endtask

    // Behaviour of one clock edge, as seen from outside the block.
    task automatic model_edge(input logic clr, input logic req, input logic pm,
                              input logic [4:0] dst, input logic [31:0] bus);
        if (!clr) begin
            for (int c = 0; c < 22; c++) m_reg[c] = 32'd0;
            m_reg[19] = PC_RST;
            m_pair = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_en = '0;
        end else if (m_pair) begin
            m_reg[16] = bus;
            m_en = 22'd1 << 16; m_ack = 1'b1; m_err = 1'b0; m_pair = 1'b0;
        end else if (req && pm) begin
            m_reg[17] = bus;
            m_en = 22'd1 << 17; m_ack = 1'b0; m_err = 1'b0; m_pair = 1'b1;
        end else if (req && dst <= 5'd21) begin
`ifdef BUS_R0_ZERO_EN
            if (dst != 5'd0) m_reg[dst] = bus;
`else
            m_reg[dst] = bus;
`endif
            m_en = 22'd1 << dst; m_ack = 1'b1; m_err = 1'b0;
        end else if (req) begin
            m_en = '0; m_ack = 1'b1; m_err = 1'b1;
        end else begin
            m_en = '0; m_ack = 1'b0; m_err = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, compare.
    task automatic step(input string name, input logic clr, input logic req, input logic pm,
                        input logic [4:0] dst, input logic [31:0] bus);
        clear = clr; load_req = req; pair_mode = pm; dest_sel = dst; BusMuxOut = bus;
        @(posedge clock);
        model_edge(clr, req, pm, dst, bus);
        #1;
        check_all(name);
    endtask

    initial begin
        clear = 1'b0; load_req = 1'b0; pair_mode = 1'b0; dest_sel = 5'd0; BusMuxOut = '0;
        m_pair = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_en = '0;
        for (int c = 0; c < 22; c++) m_reg[c] = 32'd0;

        // Reset state
        step("reset",     1'b0, 1'b0, 1'b0, 5'd0,  32'h0);
        step("idle",      1'b1, 1'b0, 1'b0, 5'd0,  32'h5555_5555);
        // Single load to R5, then ack drops
        step("r5_load",   1'b1, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF);
        step("r5_after",  1'b1, 1'b0, 1'b0, 5'd5,  32'h0);
        // Pair: LO beat, HI beat with a stray request to R3, then idle
        step("pair_lo",   1'b1, 1'b1, 1'b1, 5'd9,  32'h1111_1111);
        step("pair_hi",   1'b1, 1'b1, 1'b0, 5'd3,  32'h2222_2222);
        step("pair_done", 1'b1, 1'b0, 1'b0, 5'd3,  32'h3333_3333);
        // Invalid code
        step("bad_code",  1'b1, 1'b1, 1'b0, 5'd25, 32'hCAFE_F00D);
        step("bad_after", 1'b1, 1'b0, 1'b0, 5'd25, 32'h0);
        step("bad_31",    1'b1, 1'b1, 1'b0, 5'd31, 32'h1234_5678);
        // Pair interrupted by clear on the HI edge
        step("int_lo",    1'b1, 1'b1, 1'b1, 5'd0,  32'h4444_4444);
        step("int_clr",   1'b0, 1'b0, 1'b0, 5'd0,  32'h5555_5555);
        step("int_idle",  1'b1, 1'b0, 1'b0, 5'd0,  32'h0);
        // Back-to-back loads R1/R2/PC, then every special register and R0
        step("b2b_r1",    1'b1, 1'b1, 1'b0, 5'd1,  32'h0000_000A);
        step("b2b_r2",    1'b1, 1'b1, 1'b0, 5'd2,  32'h0000_000B);
        step("b2b_pc",    1'b1, 1'b1, 1'b0, 5'd19, 32'h0000_000C);
        step("ld_hi",     1'b1, 1'b1, 1'b0, 5'd16, 32'hA1A1_A1A1);
        step("ld_lo",     1'b1, 1'b1, 1'b0, 5'd17, 32'hB2B2_B2B2);
        step("ld_y",      1'b1, 1'b1, 1'b0, 5'd18, 32'hC3C3_C3C3);
        step("ld_mar",    1'b1, 1'b1, 1'b0, 5'd20, 32'hD4D4_D4D4);
        step("ld_ir",     1'b1, 1'b1, 1'b0, 5'd21, 32'hE5E5_E5E5);
        step("ld_r15",    1'b1, 1'b1, 1'b0, 5'd15, 32'hF6F6_F6F6);
        step("ld_r0",     1'b1, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF);
        // Pair immediately followed by a new request
        step("bb_pair_lo",1'b1, 1'b1, 1'b1, 5'd4,  32'h0101_0101);
        step("bb_pair_hi",1'b1, 1'b0, 1'b0, 5'd4,  32'h0202_0202);
        step("bb_next",   1'b1, 1'b1, 1'b0, 5'd4,  32'h0303_0303);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic        r_clr, r_req, r_pm;
            logic [4:0]  r_dst;
            logic [31:0] r_bus;
            r_clr = ($urandom_range(0, 39) != 0);
            r_req = ($urandom_range(0, 3) != 0);
            r_pm  = ($urandom_range(0, 4) == 0);
            r_dst = 5'($urandom_range(0, 31));
            r_bus = $urandom;
            step($sformatf("rnd%0d", n), r_clr, r_req, r_pm, r_dst, r_bus);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
